// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM pattern writer and read checker.
// Both ends derive the data pattern from test_pattern so they always agree.
package sdram_test_pkg;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SLOT,
      ISSUE,
      WAIT_DATA,
      COMPARE,
      DONE
   } state_t;

   // Deterministic byte pattern stored at an address: low address byte XOR seed.
   function automatic logic [7:0] test_pattern(input logic [7:0] addr, input logic [7:0] seed);
      return addr ^ seed;
   endfunction

endpackage

// File: rtl/sdram_read_checker.sv
// SDRAM read checker: sweeps START_ADDR..END_ADDR over controller port A,
// one read per port-A slot, compares every byte with the write pattern and
// logs the error count plus the first failing address/data.
module sdram_read_checker #(
   parameter int                ADDR_W     = sdram_test_pkg::ADDR_W,
   parameter int                DATA_W     = sdram_test_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(255),
   parameter logic [7:0]        SEED       = 8'h00,
   parameter int                RD_LATENCY = 4
) (
   input  logic              clk_cpu,
   input  logic              reset,
   input  logic              start,
   input  logic              phase,
   output logic              mem_oe,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data
);
   import sdram_test_pkg::*;

   // Latency counter only needs to hold RD_LATENCY-1.
   localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   state_t            state;
   logic              phase_d;
   logic              slot_rise;
   logic [LAT_W-1:0]  lat_cnt;
   logic [DATA_W-1:0] exp_data;
   logic              mismatch;

   assign slot_rise = phase & ~phase_d;
   assign exp_data  = DATA_W'(test_pattern(mem_addr[7:0], SEED));
   assign mismatch  = (mem_dout != exp_data);

   // Delayed copy of the slot strobe; a phase already high on entry never looks like a rise.
   always_ff @(posedge clk_cpu) begin
      phase_d <= phase;
   end

   // Sweep sequencer with inline error logger; all outputs registered.
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         state          <= IDLE;
         mem_oe         <= 1'b0;
         mem_addr       <= START_ADDR;
         lat_cnt        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 16'd0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= WAIT_SLOT;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  mem_addr       <= START_ADDR;
                  err_count      <= 16'd0;
                  first_err_addr <= '0;
                  first_err_data <= '0;
               end
            end
            WAIT_SLOT: begin
               if (slot_rise) begin
                  state  <= ISSUE;
                  mem_oe <= 1'b1;
               end
            end
            ISSUE: begin
               // Hold the request for the whole port-A slot.
               if (!phase) begin
                  state   <= WAIT_DATA;
                  mem_oe  <= 1'b0;
                  lat_cnt <= LAT_W'(RD_LATENCY - 1);
               end
            end
            WAIT_DATA: begin
               if (lat_cnt == '0) begin
                  state <= COMPARE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            COMPARE: begin
               if (mismatch) begin
                  if (err_count == 16'd0) begin
                     first_err_addr <= mem_addr;
                     first_err_data <= mem_dout;
                  end
                  if (err_count != 16'hFFFF) begin
                     err_count <= err_count + 16'd1;
                  end
               end
               if (mem_addr == END_ADDR) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mismatch && (err_count == 16'd0);
               end else begin
                  state    <= WAIT_SLOT;
                  mem_addr <= mem_addr + ADDR_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               mem_oe <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_read_checker.sv
// Bench for sdram_read_checker: behavioural port-A model (data valid a few
// cycles after the request ends, held until the next request), table of full
// sweeps with corruption patterns, and hand-written reset/start/saturation cases.
module tb_sdram_read_checker;
   import sdram_test_pkg::*;

   localparam int AW = 25;
   localparam int DW = 8;

   logic          clk_cpu = 1'b0;
   logic          reset;
   logic          start;
   logic          phase;
   logic          mem_oe;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;
   logic          busy;
   logic          done;
   logic          pass;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_data;

   sdram_read_checker #(
      .ADDR_W(AW), .DATA_W(DW), .START_ADDR(25'd0), .END_ADDR(25'd255),
      .SEED(8'h00), .RD_LATENCY(4)
   ) dut (
      .clk_cpu(clk_cpu), .reset(reset), .start(start), .phase(phase),
      .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .first_err_data(first_err_data)
   );

   always #5 clk_cpu = ~clk_cpu;

   int n_checks = 0;
   int n_fail   = 0;

   // Model controls, written only by the main sequence.
   int bad_a     = -1;
   int bad_b     = -1;
   bit zero_mode = 1'b0;

   // Monitor results, written only by the monitor process.
   int            bursts  = 0;
   int            seq_err = 0;

   function automatic logic [7:0] model_data(input logic [AW-1:0] a);
      if (zero_mode) return 8'h00;
      if (int'(a) == bad_a || int'(a) == bad_b) return 8'hFF;
      return a[7:0];
   endfunction

   // Slot strobe (2 high / 2 low) and port-A read data model.
   initial begin
      int pcnt;
      int since;
      pcnt     = 0;
      since    = 0;
      phase    = 1'b0;
      mem_dout = '0;
      forever begin
         @(posedge clk_cpu);
         #1;
         pcnt  = pcnt + 1;
         phase = pcnt[1];
         if (mem_oe === 1'b1) since = 0;
         else if (since < 100) since = since + 1;
         mem_dout = (mem_oe !== 1'b1 && since >= 2) ? model_data(mem_addr) : ~model_data(mem_addr);
      end
   end

   // Counts read bursts and flags any non-sequential address.
   initial begin
      logic          oe_m;
      logic [AW-1:0] last_a;
      oe_m   = 1'b0;
      last_a = '0;
      forever begin
         @(negedge clk_cpu);
         if (mem_oe === 1'b1 && oe_m !== 1'b1) begin
            bursts = bursts + 1;
            if (mem_addr != last_a + 25'd1 && mem_addr != 25'd0) seq_err = seq_err + 1;
            last_a = mem_addr;
         end
         oe_m = mem_oe;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, input string nm);
      for (int i = 0; i < lim && done !== 1'b1; i++) tick();
      check(nm, 32'(done), 32'd1);
   endtask

   task automatic wait_in(input state_t st, input logic [AW-1:0] a, input int lim, input string nm);
      for (int i = 0; i < lim && !(dut.state == st && mem_addr == a); i++) tick();
      check(nm, 32'(dut.state == st && mem_addr == a), 32'd1);
   endtask

   typedef struct {
      string nm;
      int    bad_a;
      int    bad_b;
      bit    zero;
      bit    exp_pass;
      int    exp_err;
      int    exp_faddr;
      int    exp_fdata;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int b0;
      vecs[0] = '{"clean",    -1,    -1,    1'b0, 1'b1, 0,   0,     0};
      vecs[1] = '{"bad5a",    'h5A,  -1,    1'b0, 1'b0, 1,   'h5A,  'hFF};
      vecs[2] = '{"bad10_20", 'h10,  'h20,  1'b0, 1'b0, 2,   'h10,  'hFF};
      vecs[3] = '{"allzero",  -1,    -1,    1'b1, 1'b0, 255, 1,     0};

      reset = 1'b1;
      start = 1'b0;
      repeat (3) tick();
      check("rst_mem_oe", 32'(mem_oe), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_first_addr", 32'(first_err_addr), 32'd0);
      check("rst_first_data", 32'(first_err_data), 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      // Full sweeps; every one after the first restarts from DONE.
      for (int k = 0; k < 4; k++) begin
         bad_a     = vecs[k].bad_a;
         bad_b     = vecs[k].bad_b;
         zero_mode = vecs[k].zero;
         b0        = bursts;
         pulse_start();
         check({vecs[k].nm, "_busy_on_start"}, 32'(busy), 32'd1);
         check({vecs[k].nm, "_done_cleared"}, 32'(done), 32'd0);
         check({vecs[k].nm, "_err_cleared"}, 32'(err_count), 32'd0);
         check({vecs[k].nm, "_faddr_cleared"}, 32'(first_err_addr), 32'd0);
         wait_done(4000, {vecs[k].nm, "_done"});
         check({vecs[k].nm, "_busy_end"}, 32'(busy), 32'd0);
         check({vecs[k].nm, "_pass"}, 32'(pass), 32'(vecs[k].exp_pass));
         check({vecs[k].nm, "_err_count"}, 32'(err_count), 32'(vecs[k].exp_err));
         check({vecs[k].nm, "_first_addr"}, 32'(first_err_addr), 32'(vecs[k].exp_faddr));
         check({vecs[k].nm, "_first_data"}, 32'(first_err_data), 32'(vecs[k].exp_fdata));
         check({vecs[k].nm, "_bursts"}, 32'(bursts - b0), 32'd256);
         check({vecs[k].nm, "_addr_seq"}, 32'(seq_err), 32'd0);
         repeat (3) tick();
         check({vecs[k].nm, "_done_held"}, 32'(done), 32'd1);
      end

      // Start while busy is ignored.
      bad_a = -1; bad_b = -1; zero_mode = 1'b0;
      b0 = bursts;
      pulse_start();
      repeat (100) tick();
      pulse_start();
      check("busy_start_busy", 32'(busy), 32'd1);
      wait_done(4000, "busy_start_done");
      check("busy_start_pass", 32'(pass), 32'd1);
      check("busy_start_bursts", 32'(bursts - b0), 32'd256);
      check("busy_start_seq", 32'(seq_err), 32'd0);

      // Reset while waiting for data at 0x40, then a clean restart.
      bad_a = 'h05;
      pulse_start();
      wait_in(WAIT_DATA, 25'h40, 2000, "reach_wait_data_40");
      check("pre_reset_err", 32'(err_count), 32'd1);
      reset = 1'b1;
      tick();
      check("midrst_mem_oe", 32'(mem_oe), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_err", 32'(err_count), 32'd0);
      check("midrst_addr", 32'(mem_addr), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;
      bad_a = -1;
      repeat (5) tick();
      check("idle_no_oe", 32'(mem_oe), 32'd0);
      b0 = bursts;
      pulse_start();
      wait_done(4000, "restart_done");
      check("restart_pass", 32'(pass), 32'd1);
      check("restart_err", 32'(err_count), 32'd0);
      check("restart_bursts", 32'(bursts - b0), 32'd256);

      // Error counter saturates instead of wrapping.
      zero_mode = 1'b1;
      pulse_start();
      wait_in(WAIT_DATA, 25'h80, 2000, "reach_wait_data_80");
      check("sat_pre_count", 32'(err_count), 32'd127);
      force dut.err_count = 16'hFFFF;
      tick();
      release dut.err_count;
      tick();
      check("sat_forced", 32'(err_count), 32'h0000FFFF);
      wait_done(4000, "sat_done");
      check("sat_err_count", 32'(err_count), 32'h0000FFFF);
      check("sat_pass", 32'(pass), 32'd0);
      check("sat_first_addr", 32'(first_err_addr), 32'd1);
      check("sat_first_data", 32'(first_err_data), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
